// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
// It produces the pixel counters, active-low syncs, the active-video
// qualifier, the pixel coordinates, and a frame-start strobe with a
// frame counter. Every output is a flop loaded from the *next* raster
// position, so all outputs move together on the edge that advances the
// counters. There is no combinational path from any input to any output.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       pixel_en,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Raster boundaries, expressed at counter width.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc_q, hc_d;
    logic [9:0] vc_q, vc_d;
    logic [9:0] hc_nxt, vc_nxt;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic [9:0] drawx_q, drawx_d;
    logic [9:0] drawy_q, drawy_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Compute the raster position after one pixel step, with explicit wraps.
    always_comb begin
        hc_nxt = hc_q;
        vc_nxt = vc_q;
        if (hc_q == H_LAST) begin
            hc_nxt = 10'd0;
            if (vc_q == V_LAST) begin
                vc_nxt = 10'd0;
            end else begin
                vc_nxt = vc_q + 10'd1;
            end
        end else begin
            hc_nxt = hc_q + 10'd1;
            vc_nxt = vc_q;
        end
    end

    // On an enabled edge, decode all outputs from the next position. Otherwise hold them, and drop the strobe.
    always_comb begin
        hc_d          = hc_q;
        vc_d          = vc_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_d       = blank_q;
        drawx_d       = drawx_q;
        drawy_d       = drawy_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        if (pixel_en) begin
            hc_d          = hc_nxt;
            vc_d          = vc_nxt;
            drawx_d       = hc_nxt;
            drawy_d       = vc_nxt;
            blank_d       = (hc_nxt < H_ACT_END) && (vc_nxt < V_ACT_END);
            hs_d          = !((hc_nxt >= HS_START) && (hc_nxt < HS_END));
            vs_d          = !((vc_nxt >= VS_START) && (vc_nxt < VS_END));
            frame_start_d = (hc_nxt == 10'd0) && (vc_nxt == 10'd0);
            if ((hc_nxt == 10'd0) && (vc_nxt == 10'd0)) begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                frame_cnt_d = frame_cnt_q;
            end
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State and output registers. Reset parks the counters on the last
    // pixel, so the first enabled edge lands on (0,0) and starts frame 0.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            hc_q          <= H_LAST;
            vc_q          <= V_LAST;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b0;
            drawx_q       <= 10'd0;
            drawy_q       <= 10'd0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'hFF;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            drawx_q       <= drawx_d;
            drawy_q       <= drawy_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign DrawX       = drawx_q;
    assign DrawY       = drawy_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen.
// One instance uses the full 640x480 timing and checks line-level behaviour.
// A second instance uses a tiny raster (15x13) so that frame-level behaviour,
// including the 256-frame wrap, fits in a short run. Expected outputs are
// queued by the driver and compared by a separate monitor.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       blank;
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       pixel_en;

    logic       hs_f, vs_f, blank_f, fs_f;
    logic [9:0] x_f, y_f;
    logic [7:0] fc_f;
    logic       hs_s, vs_s, blank_s, fs_s;
    logic [9:0] x_s, y_s;
    logic [7:0] fc_s;

    int total = 0;
    int bad   = 0;

    obs_t q_full[$];
    obs_t q_small[$];

    // Model state: index 0 is the full raster, index 1 is the small raster.
    bit   m_rst [2];
    int   m_x   [2];
    int   m_y   [2];
    obs_t m_obs [2];

    // Hand-computed raster constants: totals, visible extent, and sync windows [start, end).
    int ht  [2] = '{800, 15};
    int vt  [2] = '{525, 13};
    int hv  [2] = '{640, 8};
    int vv  [2] = '{480, 6};
    int hsb [2] = '{656, 10};
    int hse [2] = '{752, 13};
    int vsb [2] = '{490, 8};
    int vse [2] = '{492, 10};

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_full (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .hs          (hs_f),
        .vs          (vs_f),
        .blank       (blank_f),
        .DrawX       (x_f),
        .DrawY       (y_f),
        .frame_start (fs_f),
        .frame_cnt   (fc_f)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_VISIBLE (6), .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) dut_small (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .hs          (hs_s),
        .vs          (vs_s),
        .blank       (blank_s),
        .DrawX       (x_s),
        .DrawY       (y_s),
        .frame_start (fs_s),
        .frame_cnt   (fc_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance the model for one edge, queue the expected outputs, then clock the DUTs.
    task automatic step(input logic r, input logic pe);
        reset    = r;
        pixel_en = pe;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                m_rst[d] = 1'b1;
                m_x[d]   = 0;
                m_y[d]   = 0;
                m_obs[d] = '{hs: 1'b1, vs: 1'b1, blank: 1'b0, x: 10'd0, y: 10'd0,
                             fs: 1'b0, fc: 8'hFF};
            end else if (pe) begin
                if (m_rst[d]) begin
                    m_rst[d] = 1'b0;
                    m_x[d]   = 0;
                    m_y[d]   = 0;
                end else begin
                    m_x[d] = m_x[d] + 1;
                    if (m_x[d] == ht[d]) begin
                        m_x[d] = 0;
                        m_y[d] = (m_y[d] + 1 == vt[d]) ? 0 : m_y[d] + 1;
                    end
                end
                m_obs[d].x     = 10'(m_x[d]);
                m_obs[d].y     = 10'(m_y[d]);
                m_obs[d].blank = (m_x[d] < hv[d]) && (m_y[d] < vv[d]);
                m_obs[d].hs    = !(m_x[d] >= hsb[d] && m_x[d] < hse[d]);
                m_obs[d].vs    = !(m_y[d] >= vsb[d] && m_y[d] < vse[d]);
                m_obs[d].fs    = (m_x[d] == 0) && (m_y[d] == 0);
                if (m_obs[d].fs) m_obs[d].fc = m_obs[d].fc + 8'd1;
            end else begin
                m_obs[d].fs = 1'b0;
            end
        end
        q_full.push_back(m_obs[0]);
        q_small.push_back(m_obs[1]);
        @(posedge vga_clk);
        @(negedge vga_clk);
    endtask

    // Monitor: shortly after each edge, pop the expected outputs and compare them.
    always @(posedge vga_clk) begin
        obs_t e;
        obs_t a;
        #1;
        if (q_full.size() > 0) begin
            e = q_full.pop_front();
            a = '{hs: hs_f, vs: vs_f, blank: blank_f, x: x_f, y: y_f, fs: fs_f, fc: fc_f};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL sb_full: got hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d, expected hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d",
                         a.hs, a.vs, a.blank, a.x, a.y, a.fs, a.fc,
                         e.hs, e.vs, e.blank, e.x, e.y, e.fs, e.fc);
            end
        end
        if (q_small.size() > 0) begin
            e = q_small.pop_front();
            a = '{hs: hs_s, vs: vs_s, blank: blank_s, x: x_s, y: y_s, fs: fs_s, fc: fc_s};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL sb_small: got hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d, expected hs=%b vs=%b bl=%b x=%0d y=%0d fs=%b fc=%0d",
                         a.hs, a.vs, a.blank, a.x, a.y, a.fs, a.fc,
                         e.hs, e.vs, e.blank, e.x, e.y, e.fs, e.fc);
            end
        end
    end

    // Directed sequence, with hand-computed checks at key points.
    initial begin
        int n_hs, n_bl, n_vs, n_fs, n_fs_off;
        reset    = 1'b1;
        pixel_en = 1'b0;
        @(negedge vga_clk);

        // Reset state.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        chk("rst_x",  x_f, 0);
        chk("rst_hs", hs_f, 1);
        chk("rst_vs", vs_f, 1);
        chk("rst_bl", blank_f, 0);
        chk("rst_fc", fc_f, 255);

        // First advance, then one full line on the full-size raster.
        n_hs = 0; n_bl = 0;
        for (int i = 0; i < 800; i++) begin
            step(1'b0, 1'b1);
            if (i == 0) begin
                chk("first_fs", fs_f, 1);
                chk("first_fc", fc_f, 0);
                chk("first_bl", blank_f, 1);
                chk("first_hs", hs_f, 1);
            end
            if (i == 1) begin
                chk("second_x", x_f, 1);
                chk("second_fs", fs_f, 0);
            end
            if (y_f == 10'd0 && !hs_f) n_hs++;
            if (y_f == 10'd0 && blank_f) n_bl++;
        end
        chk("line_hs_low", n_hs, 96);
        chk("line_blank", n_bl, 640);
        chk("line_end_x", x_f, 799);
        step(1'b0, 1'b1);
        chk("line_wrap_x", x_f, 0);
        chk("line_wrap_y", y_f, 1);

        // One frame on the small raster (15 x 13 = 195 pixels).
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        n_vs = 0; n_bl = 0; n_fs = 0;
        for (int i = 0; i < 195; i++) begin
            step(1'b0, 1'b1);
            if (!vs_s) n_vs++;
            if (blank_s) n_bl++;
            if (fs_s) n_fs++;
        end
        chk("frame_vs_low", n_vs, 30);
        chk("frame_blank", n_bl, 48);
        chk("frame_fs", n_fs, 1);
        step(1'b0, 1'b1);
        chk("frame2_fs", fs_s, 1);
        chk("frame2_fc", fc_s, 1);

        // Alternate pixel_en: one frame now takes twice as many edges.
        step(1'b1, 1'b1);
        n_fs = 0; n_fs_off = 0;
        for (int i = 0; i < 390; i++) begin
            step(1'b0, (i % 2) == 0);
            if (fs_s) n_fs++;
            if (fs_s && (i % 2) == 1) n_fs_off++;
        end
        chk("alt_fs", n_fs, 1);
        chk("alt_fs_off", n_fs_off, 0);
        chk("alt_end_x", x_s, 14);
        step(1'b0, 1'b1);
        chk("alt_next_fs", fs_s, 1);
        chk("alt_next_fc", fc_s, 1);

        // Apply reset in the middle of both sync pulses, at (11,8).
        step(1'b1, 1'b0);
        for (int i = 0; i < 132; i++) step(1'b0, 1'b1);
        chk("mid_x", x_s, 11);
        chk("mid_y", y_s, 8);
        chk("mid_hs", hs_s, 0);
        chk("mid_vs", vs_s, 0);
        for (int i = 0; i < 3; i++) step(1'b1, (i % 2) == 0);
        chk("mid_rst_hs", hs_s, 1);
        chk("mid_rst_vs", vs_s, 1);
        chk("mid_rst_bl", blank_s, 0);
        chk("mid_rst_y", y_s, 0);
        chk("mid_rst_fc", fc_s, 255);
        step(1'b0, 1'b1);
        chk("mid_rel_fs", fs_s, 1);
        chk("mid_rel_fc", fc_s, 0);

        // Run 256 frames; frame_cnt must wrap.
        step(1'b1, 1'b1);
        n_fs = 0;
        for (int i = 0; i < 256 * 195; i++) begin
            step(1'b0, 1'b1);
            if (fs_s) n_fs++;
        end
        chk("wrap_fs_count", n_fs, 256);
        chk("wrap_fc_last", fc_s, 255);
        step(1'b0, 1'b1);
        chk("wrap_fc", fc_s, 0);
        chk("wrap_fs", fs_s, 1);

        @(posedge vga_clk);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
